// File: rtl/run_det_pkg.sv
// Shared types and helpers for the arbitrated run-of-ones detector.
package run_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so that index fields always have a bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/run_det.sv
// Run-of-ones counter for the currently granted stream: flags a hit when a run
// first reaches RUN_LEN, and presents a registered detect flag one cycle later.
module run_det
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_val,
  input  logic accept,
  output logic det,
  output logic hit
);

  localparam int RW = clog2(RUN_LEN + 1);

  logic [RW-1:0] run_q, run_d;
  logic          det_q, det_d;

  always_comb begin
    run_d = run_q;
    hit   = 1'b0;
    if (clear) begin
      run_d = '0;
    end else if (accept) begin
      if (bit_val) begin
        if (run_q != RW'(RUN_LEN)) begin
          run_d = run_q + RW'(1);
        end
        hit = (run_q == RW'(RUN_LEN - 1));
      end else begin
        run_d = '0;
      end
    end
    // Detect follows the counter value already in place, hence the extra cycle.
    det_d = clear ? 1'b0 : (run_q == RW'(RUN_LEN));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q <= '0;
      det_q <= 1'b0;
    end else begin
      run_q <= run_d;
      det_q <= det_d;
    end
  end

  assign det = det_q;

endmodule

// File: rtl/run_det_arb.sv
// Round-robin arbiter that lends one shared run detector to N_REQ bursty
// requesters and reports the hit count of each finished or aborted burst.
module run_det_arb
  import run_det_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          bit_in,
  input  logic [N_REQ-1:0]          bit_vld,
  input  logic [N_REQ-1:0]          bit_last,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          bit_rdy,
  output logic                      det_out,
  output logic                      done,
  output logic [clog2(N_REQ)-1:0]   done_ch,
  output logic [CNT_W-1:0]          done_hits,
  output logic                      done_abort,
  output logic                      busy
);

  localparam int CH_W = clog2(N_REQ);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]   own_q, own_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   done_ch_q, done_ch_d;
  logic [CNT_W-1:0]  done_hits_q, done_hits_d;
  logic              done_abort_q, done_abort_d;

  logic              pick_vld;
  logic [CH_W-1:0]   pick_idx;
  int                cand;

  logic              own_req, own_vld, own_bit, own_last;
  logic              accept, clear, hit;
  logic [CNT_W-1:0]  hits_inc;

  // Search upward from the slot after the previous owner, wrapping once.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_q) + i) % N_REQ;
      if (!pick_vld && req[cand[CH_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    own_req  = req[own_q];
    own_vld  = bit_vld[own_q];
    own_bit  = bit_in[own_q];
    own_last = bit_last[own_q];
    accept   = (state_q == ST_XFER) && own_vld;
    clear    = (state_q == ST_IDLE) && pick_vld;
    hits_inc = (hit && (hits_q != {CNT_W{1'b1}})) ? hits_q + CNT_W'(1) : hits_q;
  end

  run_det #(
    .RUN_LEN (RUN_LEN)
  ) u_run_det (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .bit_val (own_bit),
    .accept  (accept),
    .det     (det_out),
    .hit     (hit)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    own_d        = own_q;
    last_d       = last_q;
    hits_d       = hits_q;
    done_d       = 1'b0;
    done_ch_d    = done_ch_q;
    done_hits_d  = done_hits_q;
    done_abort_d = done_abort_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d           = ST_XFER;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          own_d             = pick_idx;
          hits_d            = '0;
        end
      end
      ST_XFER: begin
        if (accept) begin
          hits_d = hits_inc;
        end
        // A final bit wins over a simultaneous request withdrawal.
        if (accept && own_last) begin
          state_d      = ST_DONE;
          grant_d      = '0;
          done_d       = 1'b1;
          done_ch_d    = own_q;
          done_hits_d  = hits_inc;
          done_abort_d = 1'b0;
        end else if (!accept && !own_req) begin
          state_d      = ST_DONE;
          grant_d      = '0;
          done_d       = 1'b1;
          done_ch_d    = own_q;
          done_hits_d  = hits_q;
          done_abort_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = own_q;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      own_q        <= '0;
      last_q       <= CH_W'(N_REQ - 1);
      hits_q       <= '0;
      done_q       <= 1'b0;
      done_ch_q    <= '0;
      done_hits_q  <= '0;
      done_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      own_q        <= own_d;
      last_q       <= last_d;
      hits_q       <= hits_d;
      done_q       <= done_d;
      done_ch_q    <= done_ch_d;
      done_hits_q  <= done_hits_d;
      done_abort_q <= done_abort_d;
    end
  end

  assign grant      = grant_q;
  assign bit_rdy    = (state_q == ST_XFER) ? grant_q : '0;
  assign done       = done_q;
  assign done_ch    = done_ch_q;
  assign done_hits  = done_hits_q;
  assign done_abort = done_abort_q;
  assign busy       = (state_q == ST_XFER) || (state_q == ST_DONE);

endmodule

// File: doc/run_det_arb.md
RUN_DET_ARB -- requirements
Module: run_det_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the detector (2..8).
REQ-002 Parameter RUN_LEN, default 2, count of consecutive 1 bits that constitutes a hit (1..15).
REQ-003 Parameter CNT_W, default 8, width of the per-burst hit counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-006 req  input  N_REQ  per-requester burst request, held high until its burst ends.
REQ-007 bit_in  input  N_REQ  per-requester serial data bit.
REQ-008 bit_vld  input  N_REQ  per-requester bit-valid qualifier.
REQ-009 bit_last  input  N_REQ  marks the final bit of a burst, qualified by bit_vld.
REQ-010 grant  output  N_REQ  registered one-hot grant; all zero when no owner.
REQ-011 bit_rdy  output  N_REQ  equals grant while state is XFER, else zero.
REQ-012 det_out  output  1  registered; high while the current run of 1s is at least RUN_LEN.
REQ-013 done  output  1  one-cycle pulse at burst completion or abort.
REQ-014 done_ch  output  clog2(N_REQ)  index of the finished requester, valid with done.
REQ-015 done_hits  output  CNT_W  hit count of the finished burst, valid with done.
REQ-016 done_abort  output  1  high with done when the burst ended by req withdrawal.
REQ-017 busy  output  1  high in XFER and DONE.

Function
REQ-018 FSM states: IDLE, XFER, DONE; any encoding not listed SHALL return to IDLE next cycle.
REQ-019 IDLE: with any req bit high, the arbiter SHALL select one, set grant and enter XFER at the next edge (1-cycle request-to-grant latency).
REQ-020 Selection SHALL be round-robin: first set req bit searching upward from (last owner + 1) mod N_REQ; last owner resets to N_REQ-1, so channel 0 has first priority.
REQ-021 On grant, the run counter, hit counter and det_out SHALL be cleared.
REQ-022 A bit is accepted on a cycle with bit_vld[g] and bit_rdy[g] both high; bits from non-owners SHALL be ignored.
REQ-023 Accepted 1: run counter increments, saturating at RUN_LEN; accepted 0: run counter clears.
REQ-024 A hit SHALL count when an accepted 1 moves the run counter from RUN_LEN-1 to RUN_LEN; continued 1s SHALL NOT add hits until a 0 intervenes.
REQ-025 Hit counter SHALL saturate at 2^CNT_W-1.
REQ-026 det_out SHALL update one cycle after the accepting edge, high iff the run counter is at RUN_LEN.
REQ-027 An accepted bit with bit_last high SHALL be counted, then the FSM SHALL enter DONE.
REQ-028 XFER with req[g] low and no accepted bit SHALL abort: enter DONE with done_abort high; hits so far reported.
REQ-029 An accepted bit_last in the same cycle as req[g] low SHALL complete normally, not abort.
REQ-030 DONE lasts exactly one cycle: done high, grant and bit_rdy zero, last owner updated, then IDLE.
REQ-031 Minimum spacing between two grants SHALL be 2 idle cycles after the last accepted bit (DONE, IDLE).
REQ-032 done_ch, done_hits, done_abort SHALL hold their values until the next done.

Reset
REQ-033 Reset low SHALL force IDLE, grant=0, bit_rdy=0, det_out=0, done=0, done_ch=0, done_hits=0, done_abort=0, busy=0, counters=0, last owner=N_REQ-1.
REQ-034 Reset mid-XFER SHALL discard the burst without a done pulse.

Structure
REQ-035 Package run_det_pkg SHALL hold the state enumeration and a clog2 helper constant function.
REQ-036 Run counting and hit detection SHALL live in sub-module run_det (clear, bit, accept in; det, hit out); arbitration and FSM stay in run_det_arb.

Verification
REQ-037 Single req[1], bits 1,1,0,1,1,1(last) -> grant=0010 one cycle after req, done_hits=2, done_ch=1, done_abort=0.
REQ-038 req=1111 held, one-bit bursts -> grants in order 0,1,2,3,0; each done_hits=0.
REQ-039 req[2], 300 repetitions of 1,1,0 with final bit_last -> done_hits=255 (saturated).
REQ-040 req[0] dropped after bits 1,1 with no last -> done with done_abort=1, done_hits=1.
REQ-041 Non-owner bit_vld toggling during channel 3 burst 0,1,1(last) -> done_hits=1, no effect from others.
REQ-042 Reset low during XFER -> next cycle grant=0, busy=0, no done; re-request of channel 0 granted first.
